// File: rtl/mips_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package mips_pkg;

   localparam int unsigned NB_REG_DEF = 5;

   localparam logic SRC_PIPE = 1'b0;
   localparam logic SRC_DBG  = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StForce = 2'd2,
      StAck   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/wb_wait_counter.sv
// Saturating wait counter with synchronous clear; flags when the limit is reached.
module wb_wait_counter #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic at_limit_o
);

   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign at_limit_o = (cnt_q == CntW'(MAX_WAIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !at_limit_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_rf_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (priority)
// and the debug unit, forcing a pipeline stall when debug has waited too long.
module wb_rf_port_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned NB_DATA  = 32,
   parameter int unsigned NB_REG   = NB_REG_DEF,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               wb_we_i,
   input  logic [NB_REG-1:0]  wb_addr_i,
   input  logic [NB_DATA-1:0] wb_data_i,
   input  logic               dbg_req_i,
   input  logic [NB_REG-1:0]  dbg_addr_i,
   input  logic [NB_DATA-1:0] dbg_data_i,
   output logic               dbg_ack_o,
   output logic               stall_req_o,
   output logic               rf_we_o,
   output logic [NB_REG-1:0]  rf_addr_o,
   output logic [NB_DATA-1:0] rf_data_o,
   output logic               rf_src_o
);

   arb_state_e         state_q, state_d;
   logic               rf_we_q, rf_we_d;
   logic [NB_REG-1:0]  rf_addr_q, rf_addr_d;
   logic [NB_DATA-1:0] rf_data_q, rf_data_d;
   logic               rf_src_q, rf_src_d;
   logic               sel_dbg;
   logic               cnt_en;
   logic               cnt_clr;
   logic               at_limit;

   wb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .clr_i      (cnt_clr),
      .en_i       (cnt_en),
      .at_limit_o (at_limit)
   );

   always_comb begin
      state_d = state_q;
      sel_dbg = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dbg_req_i && !wb_we_i) begin
               sel_dbg = 1'b1;
               state_d = StAck;
            end else if (dbg_req_i) begin
               cnt_en  = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            // A withdrawn request is dropped silently rather than acked.
            if (!dbg_req_i) begin
               state_d = StIdle;
            end else if (!wb_we_i) begin
               sel_dbg = 1'b1;
               state_d = StAck;
            end else if (at_limit) begin
               state_d = StForce;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StForce: begin
            if (!dbg_req_i) begin
               state_d = StIdle;
            end else if (!wb_we_i) begin
               sel_dbg = 1'b1;
               state_d = StAck;
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign cnt_clr = (state_d == StIdle) || (state_d == StAck);

   always_comb begin
      rf_addr_d = sel_dbg ? dbg_addr_i : wb_addr_i;
      rf_data_d = sel_dbg ? dbg_data_i : wb_data_i;
      rf_src_d  = sel_dbg ? SRC_DBG : SRC_PIPE;
      // Writes to $zero are registered but never enabled.
      rf_we_d   = (sel_dbg || wb_we_i) && (rf_addr_d != '0);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         rf_src_q  <= SRC_PIPE;
      end else begin
         state_q   <= state_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         rf_src_q  <= rf_src_d;
      end
   end

   assign dbg_ack_o   = (state_q == StAck);
   assign stall_req_o = (state_q == StForce);
   assign rf_we_o     = rf_we_q;
   assign rf_addr_o   = rf_addr_q;
   assign rf_data_o   = rf_data_q;
   assign rf_src_o    = rf_src_q;

endmodule

// File: tb/tb_wb_rf_port_arbiter.sv
// Scoreboard bench: driver queues hand-computed per-cycle expectations, monitor compares.
module tb_wb_rf_port_arbiter;

   typedef struct packed {
      logic [15:0] id;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        src;
      logic        ack;
      logic        stall;
      logic        ad;
   } exp_t;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        wb_we_i = 1'b0;
   logic [4:0]  wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        dbg_req_i = 1'b0;
   logic [4:0]  dbg_addr_i = '0;
   logic [31:0] dbg_data_i = '0;
   logic        dbg_ack_o;
   logic        stall_req_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;
   logic        rf_src_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;
   int   vec_id   = 0;

   wb_rf_port_arbiter #(
      .NB_DATA  (32),
      .NB_REG   (5),
      .MAX_WAIT (8)
   ) dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .wb_we_i     (wb_we_i),
      .wb_addr_i   (wb_addr_i),
      .wb_data_i   (wb_data_i),
      .dbg_req_i   (dbg_req_i),
      .dbg_addr_i  (dbg_addr_i),
      .dbg_data_i  (dbg_data_i),
      .dbg_ack_o   (dbg_ack_o),
      .stall_req_o (stall_req_o),
      .rf_we_o     (rf_we_o),
      .rf_addr_o   (rf_addr_o),
      .rf_data_o   (rf_data_o),
      .rf_src_o    (rf_src_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic push_exp(input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d,
                           input logic e_src, input logic e_ack, input logic e_st,
                           input logic e_ad);
      exp_t e;
      e.id    = 16'(vec_id);
      e.we    = e_we;
      e.addr  = e_a;
      e.data  = e_d;
      e.src   = e_src;
      e.ack   = e_ack;
      e.stall = e_st;
      e.ad    = e_ad;
      vec_id++;
      exp_q.push_back(e);
      mon_en = 1'b1;
   endtask

   // Drive one cycle of stimulus at the negedge and queue the outputs expected after the edge.
   task automatic vec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic req, input logic [4:0] da, input logic [31:0] dd,
                      input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d,
                      input logic e_src, input logic e_ack, input logic e_st, input logic e_ad);
      @(negedge clock_i);
      wb_we_i    = we;
      wb_addr_i  = wa;
      wb_data_i  = wd;
      dbg_req_i  = req;
      dbg_addr_i = da;
      dbg_data_i = dd;
      push_exp(e_we, e_a, e_d, e_src, e_ack, e_st, e_ad);
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({rf_we_o, rf_addr_o, rf_data_o, rf_src_o, dbg_ack_o, stall_req_o} === '0) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got we=%b addr=%0d data=%h src=%b ack=%b stall=%b, want all zero",
                  name, rf_we_o, rf_addr_o, rf_data_o, rf_src_o, dbg_ack_o, stall_req_o);
      end
   endtask

   // Monitor: one expectation consumed per clock once the driver has started.
   always @(posedge clock_i) begin
      #1;
      if (mon_en) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL underflow: got an output cycle, want a queued expectation");
         end else begin
            exp_t e;
            logic ok;
            e  = exp_q.pop_front();
            ok = ({rf_we_o, rf_src_o, dbg_ack_o, stall_req_o} === {e.we, e.src, e.ack, e.stall});
            if (e.ad && ({rf_addr_o, rf_data_o} !== {e.addr, e.data})) ok = 1'b0;
            if (ok) begin
               n_pass++;
            end else begin
               $display({"FAIL vec%0d: got we=%b addr=%0d data=%h src=%b ack=%b stall=%b, ",
                         "want we=%b addr=%0d data=%h src=%b ack=%b stall=%b"},
                        e.id, rf_we_o, rf_addr_o, rf_data_o, rf_src_o, dbg_ack_o, stall_req_o,
                        e.we, e.addr, e.data, e.src, e.ack, e.stall);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check_zero("reset_state");
      // Reset still held across an edge.
      @(negedge clock_i);
      push_exp(0, 0, 0, 0, 0, 0, 1);
      @(negedge clock_i);
      reset_i = 1'b0;
      wb_we_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'hDEADBEEF;
      push_exp(1, 5'd8, 32'hDEADBEEF, 0, 0, 0, 1);

      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Debug on an idle port.
      vec(0, 0, 0, 1, 5'd3, 32'h12345678,                   1, 5'd3, 32'h12345678, 1, 1, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Contention: three pipeline writes win, then debug.
      vec(1, 5'd1, 32'h11, 1, 5'd10, 32'hA5A5A5A5,          1, 5'd1, 32'h11, 0, 0, 0, 1);
      vec(1, 5'd2, 32'h22, 1, 5'd10, 32'hA5A5A5A5,          1, 5'd2, 32'h22, 0, 0, 0, 1);
      vec(1, 5'd3, 32'h33, 1, 5'd10, 32'hA5A5A5A5,          1, 5'd3, 32'h33, 0, 0, 0, 1);
      vec(0, 0, 0, 1, 5'd10, 32'hA5A5A5A5,                  1, 5'd10, 32'hA5A5A5A5, 1, 1, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Pipeline write accepted during the ack cycle.
      vec(0, 0, 0, 1, 5'd4, 32'h44,                         1, 5'd4, 32'h44, 1, 1, 0, 1);
      vec(1, 5'd5, 32'h55, 0, 0, 0,                         1, 5'd5, 32'h55, 0, 0, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Starvation: 8 waiting cycles then stall; drop wb_we two cycles after stall rises.
      for (int k = 0; k < 10; k++) begin
         vec(1, 5'd9, 32'(k), 1, 5'd7, 32'h77,              1, 5'd9, 32'(k), 0, 0, k >= 8, 1);
      end
      vec(0, 0, 0, 1, 5'd7, 32'h77,                         1, 5'd7, 32'h77, 1, 1, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Writes to $zero are suppressed; debug is still acked.
      vec(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF,                   0, 5'd0, 32'hFFFFFFFF, 1, 1, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      vec(1, 5'd0, 32'hCAFEF00D, 0, 0, 0,                   0, 5'd0, 32'hCAFEF00D, 0, 0, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Request withdrawn while waiting: back to idle with no ack.
      vec(1, 5'd12, 32'h1, 1, 5'd6, 32'h66,                 1, 5'd12, 32'h1, 0, 0, 0, 1);
      vec(1, 5'd13, 32'h2, 0, 0, 0,                         1, 5'd13, 32'h2, 0, 0, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);
      // Drive into FORCE again, then reset asynchronously mid-cycle.
      for (int k = 0; k < 10; k++) begin
         vec(1, 5'd9, 32'(k + 100), 1, 5'd2, 32'h22222222,  1, 5'd9, 32'(k + 100), 0, 0, k >= 8, 1);
      end
      @(negedge clock_i);
      wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
      #2;
      reset_i = 1'b1;
      #1;
      check_zero("async_reset_mid_force");
      push_exp(0, 0, 0, 0, 0, 0, 1);
      @(negedge clock_i);
      reset_i = 1'b0;
      push_exp(1, 5'd2, 32'h22222222, 1, 1, 0, 1);
      vec(0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 0);

      @(posedge clock_i);
      #2;
      mon_en = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_rf_port_arbiter.md
Name: wb_rf_port_arbiter

Overview:
- Owns the single register-file write port downstream of the writeback mux.
- Shares that port between two requesters: the pipeline writeback (fixed priority) and the debug unit, which writes registers over a req/ack handshake.
- Prevents debug starvation: after a bounded wait it raises a pipeline stall request to force a free slot.
- All register-file write outputs are registered; sits between the writeback stage and the register bank.

Parameters:
- NB_DATA, 32, data width of the write port.
- NB_REG, 5, register address width.
- MAX_WAIT, 8, cycles a pending debug request may be blocked before stall_req_o is raised; must be >= 1.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- wb_we_i  in  1  pipeline writeback register-write enable.
- wb_addr_i  in  NB_REG  pipeline destination register.
- wb_data_i  in  NB_DATA  writeback mux result.
- dbg_req_i  in  1  debug write request; held high until acknowledged.
- dbg_addr_i  in  NB_REG  debug destination register; stable while dbg_req_i is high.
- dbg_data_i  in  NB_DATA  debug write data; stable while dbg_req_i is high.
- dbg_ack_o  out  1  one-cycle pulse: the debug write has been issued.
- stall_req_o  out  1  request to the hazard unit to freeze the pipeline.
- rf_we_o  out  1  register-file write enable (registered).
- rf_addr_o  out  NB_REG  register-file write address (registered).
- rf_data_o  out  NB_DATA  register-file write data (registered).
- rf_src_o  out  1  source of the current write: 0 = pipeline, 1 = debug.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Reset is asynchronous and takes effect mid-operation.
  - A pending debug request is dropped. Because the requester still holds dbg_req_i, it is re-arbitrated after reset.
- Latency: a granted write appears on rf_* exactly 1 cycle after the cycle it is selected.
- Priority:
  - When wb_we_i = 1, the pipeline write is always selected.
  - A debug write is never issued in the same cycle as a pipeline write.
- $zero suppression: a selected write with address 0 drives rf_we_o = 0. Address and data are still registered. For debug, this still counts as served and is acked.
- Handshake:
  - dbg_ack_o is high for exactly 1 cycle, in the same cycle rf_we_o presents the debug write.
  - The requester drops dbg_req_i in the cycle it samples the ack.
  - The arbiter ignores dbg_req_i while in ACK, so there is no double grant.
- FSM states:
  - IDLE:
    - dbg_req_i & !wb_we_i -> select debug, go ACK.
    - dbg_req_i & wb_we_i -> select pipeline, wait_cnt = 1, go WAIT.
    - Otherwise -> pass the pipeline through.
  - WAIT:
    - Pipeline passes through.
    - !wb_we_i -> select debug, go ACK.
    - Else if wait_cnt == MAX_WAIT -> go FORCE.
    - Else wait_cnt++.
  - FORCE:
    - stall_req_o = 1 (registered; asserted on entry).
    - Pipeline writes still pass through while wb_we_i = 1.
    - First cycle with !wb_we_i -> select debug, go ACK.
    - stall_req_o deasserts on leaving FORCE.
  - ACK:
    - dbg_ack_o = 1; rf_src_o = 1.
    - wb_we_i is still honoured and selected for the next cycle.
    - Next state is always IDLE.
- Counter: width clog2(MAX_WAIT+1); saturates at MAX_WAIT and is cleared on entering IDLE. No wrap-around is possible.
- dbg_req_i deasserted while in WAIT or FORCE (protocol violation tolerance) -> return to IDLE with stall_req_o = 0 and no ack.
- Hazard-unit contract: while stall_req_o = 1, the pipeline holds its WB instruction and presents wb_we_i = 0 within MAX_WAIT cycles. No pipeline write is lost, because the held instruction is replayed after the stall.

Decomposition:
- Shared package (mips_pkg):
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, FORCE=2'd2, ACK=2'd3.
  - NB_REG default.
  - Source constants: SRC_PIPE=1'b0, SRC_DBG=1'b1.
- One sub-module is natural: wb_wait_counter, a saturating counter with clear, enable, and a limit-reached flag.
- Output registers and FSM stay in the top module.

Test Plan:
- Reset: assert reset_i mid-FORCE with dbg_req_i=1 -> all outputs 0 immediately; after release with wb_we_i=0, ack appears 1 cycle later.
- Pipeline only: wb_we_i=1, addr=5'd8, data=32'hDEADBEEF -> next cycle rf_we_o=1, rf_addr_o=8, rf_data_o=32'hDEADBEEF, rf_src_o=0, dbg_ack_o=0.
- Idle-port debug: dbg_req_i=1, addr=5'd3, data=32'h12345678, wb_we_i=0 -> next cycle rf_we_o=1, rf_addr_o=3, rf_src_o=1, dbg_ack_o=1 for exactly 1 cycle.
- Contention:
  - Stimulus: dbg_req_i held, wb_we_i=1 for 3 cycles, then 0.
  - Response: 3 pipeline writes issued in order, then the debug write with ack; stall_req_o never asserts.
- Starvation, MAX_WAIT=8:
  - Stimulus: dbg_req_i held, wb_we_i=1 continuously; wb_we_i dropped 2 cycles after stall_req_o rises.
  - Response: stall_req_o rises after 8 blocked cycles; the debug write is issued and acked on the following cycle; stall_req_o falls after the ack.
- $zero: debug write with addr 0 and data 32'hFFFFFFFF -> rf_we_o=0, dbg_ack_o=1; the same holds for a pipeline write to addr 0, which gives rf_we_o=0.
